// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: machine width, canonical NOP and fetch FSM states.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, issues word reads on the shared memory port and
// presents the fetched word to decode through a valid/ready instruction register.
module instruction_fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_fault
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            discard;
    logic            outstanding;
    logic            redirect_misaligned;

    assign pc_next             = pc + 32'd4;
    assign redirect_misaligned = |redirect_pc[1:0];

    // A response is still owed if the request is granted now, or we are waiting
    // and it has not arrived this very cycle.
    always_comb begin
        outstanding = 1'b0;
        if (state == REQ && mem_gnt)
            outstanding = 1'b1;
        else if (state == WAIT && !mem_rvalid)
            outstanding = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            discard     <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= word_align(RESET_PC);
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            instr_pc    <= '0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            mem_addr    <= word_align(redirect_pc);
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            if (outstanding) begin
                discard <= 1'b1;
                mem_req <= 1'b0;
                state   <= WAIT;
            end else begin
                discard <= 1'b0;
                if (redirect_misaligned) begin
                    mem_req <= 1'b0;
                    state   <= FAULT;
                end else begin
                    mem_req <= 1'b1;
                    state   <= REQ;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    mem_req  <= 1'b1;
                    mem_addr <= word_align(pc);
                    state    <= REQ;
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (discard) begin
                            // Stale response from before a redirect; pc already holds the target.
                            discard <= 1'b0;
                            if (|pc[1:0]) begin
                                state <= FAULT;
                            end else begin
                                mem_req  <= 1'b1;
                                mem_addr <= word_align(pc);
                                state    <= REQ;
                            end
                        end else begin
                            instruction <= mem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc_next;
                        mem_req     <= 1'b1;
                        mem_addr    <= word_align(pc_next);
                        state       <= REQ;
                    end
                end
                FAULT: begin
                    // Present a faulting NOP at the bad target until decode redirects us.
                    instr_valid <= 1'b1;
                    fetch_fault <= 1'b1;
                    instruction <= NOP_INSTR;
                    instr_pc    <= pc;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a response scoreboard.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_entry_t;

    sb_entry_t   sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instruction, 32'h0000_0013);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    endtask

    task automatic wait_req(input int max_cycles);
        int n = 0;
        while (mem_req !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("req_timeout", {31'b0, mem_req}, 32'd1);
    endtask

    task automatic fetch_one(input logic [31:0] data, input int gnt_delay,
                             input int lat, input int ready_delay);
        sb_entry_t e;
        wait_req(10);
        chk("req_addr", mem_addr, exp_pc);
        repeat (gnt_delay) begin
            tick();
            chk("stall_req", {31'b0, mem_req}, 32'd1);
            chk("stall_addr", mem_addr, exp_pc);
            chk("stall_valid", {31'b0, instr_valid}, 32'd0);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("gnt_drop", {31'b0, mem_req}, 32'd0);
        repeat (lat - 1) begin
            tick();
            chk("lat_valid", {31'b0, instr_valid}, 32'd0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        sb.push_back('{instr: data, pc: exp_pc});
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hx;
        chk("instr_valid", {31'b0, instr_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("instruction", instruction, e.instr);
        chk("instr_pc", instr_pc, e.pc);
        repeat (ready_delay) begin
            tick();
            chk("hold_instr", instruction, e.instr);
            chk("hold_pc", instr_pc, e.pc);
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("hold_noreq", {31'b0, mem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        exp_pc = exp_pc + 32'd4;
        chk("hs_valid", {31'b0, instr_valid}, 32'd0);
        chk("next_req", {31'b0, mem_req}, 32'd1);
        chk("next_addr", mem_addr, exp_pc);
    endtask

    initial begin
        rst_n          = 1'b0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        exp_pc         = 32'h0;
        tick();
        tick();
        chk_reset_vals();
        rst_n = 1'b1;

        // Zero-wait fetch, arbiter stall, slow memory with decode back-pressure.
        fetch_one(32'h0010_0093, 0, 1, 0);
        fetch_one(32'h0020_0113, 4, 1, 0);
        fetch_one(32'h0030_0193, 0, 3, 5);

        // Redirect while a response is pending: the late response must be dropped.
        wait_req(10);
        chk("rd_wait_addr", mem_addr, 32'h0000_000C);
        mem_gnt = 1'b1;
        tick();
        mem_gnt        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("rd_wait_valid", {31'b0, instr_valid}, 32'd0);
        chk("rd_wait_noreq", {31'b0, mem_req}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        chk("rd_drop_valid", {31'b0, instr_valid}, 32'd0);
        chk("rd_new_req", {31'b0, mem_req}, 32'd1);
        chk("rd_new_addr", mem_addr, 32'h0000_0100);
        exp_pc = 32'h0000_0100;
        fetch_one(32'h0040_0213, 0, 1, 0);

        // Response and redirect in the same WAIT cycle: nothing left to discard.
        wait_req(10);
        mem_gnt = 1'b1;
        tick();
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b1;
        mem_rdata      = 32'hBAAD_F00D;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        mem_rvalid     = 1'b0;
        redirect_valid = 1'b0;
        chk("rs_valid", {31'b0, instr_valid}, 32'd0);
        chk("rs_req", {31'b0, mem_req}, 32'd1);
        chk("rs_addr", mem_addr, 32'h0000_0300);
        exp_pc = 32'h0000_0300;
        fetch_one(32'h0050_0293, 1, 2, 1);

        // Misaligned redirect parks in FAULT until a good redirect arrives.
        wait_req(10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("flt_first_valid", {31'b0, instr_valid}, 32'd0);
        chk("flt_noreq", {31'b0, mem_req}, 32'd0);
        instr_ready = 1'b1;
        repeat (4) begin
            tick();
            chk("flt_valid", {31'b0, instr_valid}, 32'd1);
            chk("flt_fault", {31'b0, fetch_fault}, 32'd1);
            chk("flt_hold_noreq", {31'b0, mem_req}, 32'd0);
        end
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("flt_exit_valid", {31'b0, instr_valid}, 32'd0);
        chk("flt_exit_fault", {31'b0, fetch_fault}, 32'd0);
        chk("flt_exit_req", {31'b0, mem_req}, 32'd1);
        chk("flt_exit_addr", mem_addr, 32'h0000_0200);
        exp_pc = 32'h0000_0200;
        fetch_one(32'h0060_0313, 0, 1, 0);

        // Reset in WAIT, then a stray response after release.
        wait_req(10);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_valid", {31'b0, instr_valid}, 32'd0);
        exp_pc = 32'h0;
        fetch_one(32'h0070_0393, 0, 1, 0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
